// File: rtl/dram_responder.sv
// ============================================================================
// Module   : dram_responder
// Purpose  : Behavioural DRAM-like responder. Accepts one read or write
//            request at a time and answers after a fixed latency with a
//            single-cycle ready pulse. The backing store holds 2^ADDR_W
//            32-bit words addressed by a halfword address.
// Ports    : clk        - clock, all state changes on the rising edge
//            rstn       - asynchronous active-low reset
//            valid_dram - request valid from the initiator
//            rw_dram    - 1 = write, 0 = read
//            addr_dram  - halfword address, word index = addr_dram[ADDR_W:1]
//            din_dram   - write data
//            dout_dram  - read data, held until the next read completes
//            ready_dram - single-cycle completion pulse
//            err_dram   - sticky protocol-error flag
// Options  : DRAM_RESPONDER_CHECK_EN - when defined, a protocol checker drives
//            err_dram; when undefined err_dram is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_responder #(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 4,
  parameter int WR_LAT = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        valid_dram,
  input  logic        rw_dram,
  input  logic [26:0] addr_dram,
  input  logic [31:0] din_dram,
  output logic [31:0] dout_dram,
  output logic        ready_dram,
  output logic        err_dram
);

  // Counter preload values: the counter holds the number of BUSY edges left.
  localparam logic [7:0] RD_CNT = 8'(RD_LAT - 1);
  localparam logic [7:0] WR_CNT = 8'(WR_LAT - 1);
  localparam int         DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t             state;
  logic [7:0]         cnt;
  logic               lat_rw;
  logic [ADDR_W-1:0]  lat_idx;
  logic [31:0]        lat_din;
  logic [31:0]        mem [DEPTH];

  logic [ADDR_W-1:0]  req_idx;
  logic [7:0]         req_cnt;

  assign req_idx = addr_dram[ADDR_W:1];
  assign req_cnt = rw_dram ? WR_CNT : RD_CNT;

  // Upper address bits and bit 0 alias away by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_dram[26:ADDR_W+1], addr_dram[0]};

  // Control path. ready_dram is registered and rises exactly on entry to RESP.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      ready_dram <= 1'b0;
      dout_dram  <= 32'h0;
      lat_rw     <= 1'b0;
      lat_idx    <= '0;
      lat_din    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          ready_dram <= 1'b0;
          if (valid_dram) begin
            lat_rw  <= rw_dram;
            lat_idx <= req_idx;
            lat_din <= din_dram;
            cnt     <= req_cnt;
            if (req_cnt == 8'd0) begin
              // Single-cycle latency: respond straight away.
              state      <= RESP;
              ready_dram <= 1'b1;
              if (!rw_dram) begin
                dout_dram <= mem[req_idx];
              end
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt <= 8'd1) begin
            cnt        <= 8'd0;
            state      <= RESP;
            ready_dram <= 1'b1;
            if (!lat_rw) begin
              dout_dram <= mem[lat_idx];
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP: begin
          ready_dram <= 1'b0;
          // A still-asserted valid belongs to the request just served.
          state      <= valid_dram ? DRAIN : IDLE;
        end
        DRAIN: begin
          ready_dram <= 1'b0;
          if (!valid_dram) begin
            state <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          ready_dram <= 1'b0;
        end
      endcase
    end
  end

  // Storage is never reset. A write commits on the edge that ends RESP; a
  // reset before that edge returns state to IDLE so the write is dropped.
  always_ff @(posedge clk) begin
    if (state == RESP && lat_rw) begin
      mem[lat_idx] <= lat_din;
    end
  end

`ifdef DRAM_RESPONDER_CHECK_EN
  // Full copy of the accepted request so any change on the bus is visible,
  // including address bits that alias away in the storage index.
  logic        chk_rw;
  logic [26:0] chk_addr;
  logic [31:0] chk_din;
  logic        err_q;
  logic        in_flight;
  logic        req_changed;

  assign in_flight   = (state == BUSY) || (state == RESP);
  assign req_changed = (rw_dram != chk_rw) || (addr_dram != chk_addr) ||
                       (din_dram != chk_din);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chk_rw   <= 1'b0;
      chk_addr <= 27'h0;
      chk_din  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      if (state == IDLE && valid_dram) begin
        chk_rw   <= rw_dram;
        chk_addr <= addr_dram;
        chk_din  <= din_dram;
      end
      if (((state == BUSY) && !valid_dram) ||
          (in_flight && valid_dram && req_changed)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_dram = err_q;
`else
  assign err_dram = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dram_responder.sv
// ============================================================================
// Module   : tb_dram_responder
// Purpose  : Self-checking bench for dram_responder. Stimulus pushes the
//            expected completion (cycle and read data) into a queue; a monitor
//            pops and compares on every ready pulse. A second instance with
//            single-cycle latencies covers the latency corner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dram_responder;

`ifdef DRAM_RESPONDER_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        valid_dram = 1'b0;
  logic        rw_dram = 1'b0;
  logic [26:0] addr_dram = 27'h0;
  logic [31:0] din_dram = 32'h0;
  logic [31:0] dout_dram;
  logic        ready_dram;
  logic        err_dram;

  logic        v1 = 1'b0;
  logic        rw1 = 1'b0;
  logic [26:0] a1 = 27'h0;
  logic [31:0] d1 = 32'h0;
  logic [31:0] dout1;
  logic        ready1;
  logic        err1;

  dram_responder #(.ADDR_W(12), .RD_LAT(4), .WR_LAT(2)) dut (
    .clk(clk), .rstn(rstn), .valid_dram(valid_dram), .rw_dram(rw_dram),
    .addr_dram(addr_dram), .din_dram(din_dram), .dout_dram(dout_dram),
    .ready_dram(ready_dram), .err_dram(err_dram)
  );

  dram_responder #(.ADDR_W(12), .RD_LAT(1), .WR_LAT(1)) dut_l1 (
    .clk(clk), .rstn(rstn), .valid_dram(v1), .rw_dram(rw1),
    .addr_dram(a1), .din_dram(d1), .dout_dram(dout1),
    .ready_dram(ready1), .err_dram(err1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] exp_dout = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rstn && ready_dram) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_ready: got ready=1 at cycle %0d, required no pulse", cyc);
      end else begin
        mon_e = sb.pop_front();
        if (cyc != mon_e.cyc) begin
          n_fail++;
          $display("FAIL ready_latency: got cycle %0d, required cycle %0d", cyc, mon_e.cyc);
        end
        n_tests++;
        if (dout_dram !== mon_e.data) begin
          n_fail++;
          $display("FAIL dout_%s: got %h, required %h", mon_e.rd ? "read" : "hold",
                   dout_dram, mon_e.data);
        end
      end
    end
  end

  // Returns at the negedge of the RESP cycle.
  task automatic wait_ready();
    bit got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = ready_dram;
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL ready_timeout: got no ready in 50 cycles, required a pulse");
    end
  endtask

  task automatic do_req(input bit rw, input logic [26:0] a, input logic [31:0] d,
                        input logic [31:0] rd_exp, input int hold);
    int lat;
    lat = rw ? 2 : 4;
    @(negedge clk);
    valid_dram = 1'b1;
    rw_dram    = rw;
    addr_dram  = a;
    din_dram   = d;
    if (!rw) exp_dout = rd_exp;
    sb.push_back('{rd: !rw, data: exp_dout, cyc: cyc + lat});
    wait_ready();
    repeat (hold) @(negedge clk);
    valid_dram = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rstn = 1'b0;
    #1;
    check("reset_ready", {31'h0, ready_dram}, 32'h0);
    check("reset_dout", dout_dram, 32'h0);
    check("reset_err", {31'h0, err_dram}, 32'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Write then read back with default latencies.
    do_req(1'b1, 27'h10, 32'hDEADBEEF, 32'h0, 0);
    do_req(1'b0, 27'h10, 32'h0, 32'hDEADBEEF, 0);

    // Held valid: no second acceptance, then one fresh read after a 1-cycle gap.
    do_req(1'b0, 27'h10, 32'h0, 32'hDEADBEEF, 6);
    do_req(1'b0, 27'h10, 32'h0, 32'hDEADBEEF, 0);

    // Aliasing: 0x0002 and 0x2002 share word index 1; dout holds across a write.
    do_req(1'b1, 27'h0002, 32'h12345678, 32'h0, 0);
    do_req(1'b0, 27'h2002, 32'h0, 32'h12345678, 0);
    do_req(1'b1, 27'h0004, 32'h0BADF00D, 32'h0, 0);
    do_req(1'b0, 27'h0004, 32'h0, 32'h0BADF00D, 0);
    do_req(1'b0, 27'h0002, 32'h0, 32'h12345678, 0);

    // Known contents for the reset-discard test.
    do_req(1'b1, 27'h20, 32'h11112222, 32'h0, 0);

    // Address changes mid-BUSY: the latched request still completes.
    @(negedge clk);
    valid_dram = 1'b1;
    rw_dram    = 1'b0;
    addr_dram  = 27'h10;
    exp_dout   = 32'hDEADBEEF;
    sb.push_back('{rd: 1'b1, data: exp_dout, cyc: cyc + 4});
    @(negedge clk);
    addr_dram = 27'h30;
    wait_ready();
    valid_dram = 1'b0;
    @(negedge clk);
    check("err_after_addr_change", {31'h0, err_dram}, {31'h0, EXP_ERR});
    repeat (3) @(negedge clk);
    check("err_sticky", {31'h0, err_dram}, {31'h0, EXP_ERR});

    // Reset mid-BUSY on a write: outputs clear at once, write is discarded.
    @(negedge clk);
    valid_dram = 1'b1;
    rw_dram    = 1'b1;
    addr_dram  = 27'h20;
    din_dram   = 32'hAAAA5555;
    @(posedge clk);
    #1 rstn = 1'b0;
    valid_dram = 1'b0;
    #1;
    check("rst_busy_ready", {31'h0, ready_dram}, 32'h0);
    check("rst_busy_dout", dout_dram, 32'h0);
    check("rst_busy_err", {31'h0, err_dram}, 32'h0);
    exp_dout = 32'h0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    do_req(1'b0, 27'h20, 32'h0, 32'h11112222, 0);

    // Single-cycle latency instance.
    @(negedge clk);
    v1 = 1'b1; rw1 = 1'b1; a1 = 27'h40; d1 = 32'hCAFEF00D;
    @(negedge clk);
    check("l1_wr_ready", {31'h0, ready1}, 32'h1);
    check("l1_wr_dout", dout1, 32'h0);
    v1 = 1'b0;
    @(negedge clk);
    check("l1_wr_ready_low", {31'h0, ready1}, 32'h0);
    v1 = 1'b1; rw1 = 1'b0;
    @(negedge clk);
    check("l1_rd_ready", {31'h0, ready1}, 32'h1);
    check("l1_rd_dout", dout1, 32'hCAFEF00D);
    v1 = 1'b0;
    @(negedge clk);
    check("l1_rd_ready_low", {31'h0, ready1}, 32'h0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
